// File: rtl/alu_arbiter.sv
// Two-port round-robin arbiter that shares one combinational ALU.
// Operands and results are registered, so the ALU sees stable inputs for the whole EXEC cycle.
module alu_arbiter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [DATA_WIDTH-1:0] req0_op1,
  input  logic [DATA_WIDTH-1:0] req0_op2,
  input  logic [2:0]            req0_ctrl,
  input  logic [DATA_WIDTH-1:0] req1_op1,
  input  logic [DATA_WIDTH-1:0] req1_op2,
  input  logic [2:0]            req1_ctrl,
  output logic [1:0]            resp_valid,
  input  logic [1:0]            resp_ready,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  resp_zero,
  output logic [DATA_WIDTH-1:0] alu_op1_o,
  output logic [DATA_WIDTH-1:0] alu_op2_o,
  output logic [2:0]            alu_ctrl_o,
  input  logic [DATA_WIDTH-1:0] alu_out_i,
  input  logic                  alu_zero_i,
  output logic                  busy_o
);

  // state | meaning
  // IDLE  | waiting for a request; req_ready driven from the arbiter
  // EXEC  | latched operands on the ALU; result captured at end of cycle
  // RESP  | result held for the owner until its resp_ready
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t                state_q, state_d;
  logic                  ptr_q, ptr_d;
  logic                  owner_q, owner_d;
  logic [DATA_WIDTH-1:0] op1_q, op1_d;
  logic [DATA_WIDTH-1:0] op2_q, op2_d;
  logic [2:0]            ctrl_q, ctrl_d;
  logic [DATA_WIDTH-1:0] res_q, res_d;
  logic                  zero_q, zero_d;
  logic [1:0]            grant;

  // A lone requester always wins; the pointer only breaks ties.
  assign grant[0] = req_valid[0] & (~req_valid[1] | ~ptr_q);
  assign grant[1] = req_valid[1] & (~req_valid[0] | ptr_q);

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    op1_d      = op1_q;
    op2_d      = op2_q;
    ctrl_d     = ctrl_q;
    res_d      = res_q;
    zero_d     = zero_q;
    req_ready  = 2'b00;
    resp_valid = 2'b00;
    case (state_q)
      IDLE: begin
        req_ready = grant;
        if (grant[0]) begin
          op1_d   = req0_op1;
          op2_d   = req0_op2;
          ctrl_d  = req0_ctrl;
          owner_d = 1'b0;
          state_d = EXEC;
        end else if (grant[1]) begin
          op1_d   = req1_op1;
          op2_d   = req1_op2;
          ctrl_d  = req1_ctrl;
          owner_d = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        res_d   = alu_out_i;
        zero_d  = alu_zero_i;
        ptr_d   = ~owner_q;
        state_d = RESP;
      end
      RESP: begin
        resp_valid[owner_q] = 1'b1;
        if (resp_ready[owner_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      owner_q <= 1'b0;
      op1_q   <= '0;
      op2_q   <= '0;
      ctrl_q  <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      ctrl_q  <= ctrl_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
    end
  end

  assign alu_op1_o  = op1_q;
  assign alu_op2_o  = op2_q;
  assign alu_ctrl_o = ctrl_q;
  assign resp_data  = res_q;
  assign resp_zero  = zero_q;
  assign busy_o     = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU on the alu_* ports.
module tb_alu_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req0_op1, req0_op2, req1_op1, req1_op2;
  logic [2:0]  req0_ctrl, req1_ctrl;
  logic [1:0]  resp_valid;
  logic [1:0]  resp_ready;
  logic [31:0] resp_data;
  logic        resp_zero;
  logic [31:0] alu_op1_o, alu_op2_o;
  logic [2:0]  alu_ctrl_o;
  logic [31:0] alu_out_i;
  logic        alu_zero_i;
  logic        busy_o;

  int n_tests = 0;
  int n_fail  = 0;

  alu_arbiter #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_op1(req0_op1), .req0_op2(req0_op2), .req0_ctrl(req0_ctrl),
    .req1_op1(req1_op1), .req1_op2(req1_op2), .req1_ctrl(req1_ctrl),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_zero(resp_zero),
    .alu_op1_o(alu_op1_o), .alu_op2_o(alu_op2_o), .alu_ctrl_o(alu_ctrl_o),
    .alu_out_i(alu_out_i), .alu_zero_i(alu_zero_i),
    .busy_o(busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    case (alu_ctrl_o)
      3'd1:    alu_out_i = alu_op1_o - alu_op2_o;
      3'd2:    alu_out_i = alu_op1_o & alu_op2_o;
      3'd3:    alu_out_i = alu_op1_o | alu_op2_o;
      3'd4:    alu_out_i = (alu_op1_o < alu_op2_o) ? 32'd1 : 32'd0;
      3'd5:    alu_out_i = alu_op1_o << alu_op2_o[4:0];
      3'd6:    alu_out_i = alu_op2_o;
      default: alu_out_i = alu_op1_o + alu_op2_o;
    endcase
    alu_zero_i = (alu_out_i == 32'd0);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled mid-low-phase.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 2'b00; resp_ready = 2'b00;
    req0_op1 = '0; req0_op2 = '0; req0_ctrl = '0;
    req1_op1 = '0; req1_op2 = '0; req1_ctrl = '0;
    #12;
    chk("rst_resp_valid", {30'd0, resp_valid}, 32'd0);
    chk("rst_req_ready", {30'd0, req_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_alu_op1", alu_op1_o, 32'd0);
    @(negedge clk); rst_n = 1'b1; #1;

    // Single ADD from requester 0
    req_valid = 2'b01; req0_op1 = 32'd5; req0_op2 = 32'd7; req0_ctrl = 3'd0; resp_ready = 2'b11;
    #1;
    chk("add_req_ready", {30'd0, req_ready}, 32'd1);
    step(); req_valid = 2'b00; #1;
    chk("add_exec_op1", alu_op1_o, 32'd5);
    chk("add_exec_op2", alu_op2_o, 32'd7);
    chk("add_exec_ctrl", {29'd0, alu_ctrl_o}, 32'd0);
    chk("add_exec_busy", {31'd0, busy_o}, 32'd1);
    chk("add_exec_ready", {30'd0, req_ready}, 32'd0);
    step();
    chk("add_resp_valid", {30'd0, resp_valid}, 32'd1);
    chk("add_resp_data", resp_data, 32'd12);
    chk("add_resp_zero", {31'd0, resp_zero}, 32'd0);
    step();
    chk("add_idle_busy", {31'd0, busy_o}, 32'd0);
    chk("add_idle_valid", {30'd0, resp_valid}, 32'd0);

    // SUB to zero from requester 1
    req_valid = 2'b10; req1_op1 = 32'd9; req1_op2 = 32'd9; req1_ctrl = 3'd1; #1;
    chk("sub_req_ready", {30'd0, req_ready}, 32'd2);
    step(); req_valid = 2'b00;
    step();
    chk("sub_resp_valid", {30'd0, resp_valid}, 32'd2);
    chk("sub_resp_data", resp_data, 32'd0);
    chk("sub_resp_zero", {31'd0, resp_zero}, 32'd1);
    step();

    // Contention: both valid, grants alternate 0,1,0,1
    req0_op1 = 32'hF0; req0_op2 = 32'h0F; req0_ctrl = 3'd3;
    req1_op1 = 32'd1;  req1_op2 = 32'd4;  req1_ctrl = 3'd5;
    req_valid = 2'b11; #1;
    for (int g = 0; g < 4; g++) begin
      chk($sformatf("cont_grant%0d", g), {30'd0, req_ready}, (g % 2 == 0) ? 32'd1 : 32'd2);
      step();
      chk($sformatf("cont_exec_ready%0d", g), {30'd0, req_ready}, 32'd0);
      step();
      chk($sformatf("cont_resp_valid%0d", g), {30'd0, resp_valid}, (g % 2 == 0) ? 32'd1 : 32'd2);
      chk($sformatf("cont_resp_data%0d", g), resp_data, (g % 2 == 0) ? 32'hFF : 32'd16);
      step();
    end
    req_valid = 2'b00; #1;

    // Backpressure on requester 0 while requester 1 waits with a PASSOP2
    req0_op1 = 32'd3; req0_op2 = 32'd8; req0_ctrl = 3'd4; resp_ready = 2'b00;
    req_valid = 2'b01; #1;
    chk("bp_req_ready", {30'd0, req_ready}, 32'd1);
    step();
    req_valid = 2'b10; req1_op1 = 32'd0; req1_op2 = 32'hDEADBEEF; req1_ctrl = 3'd6;
    step();
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp_hold_valid%0d", c), {30'd0, resp_valid}, 32'd1);
      chk($sformatf("bp_hold_data%0d", c), resp_data, 32'd1);
      chk($sformatf("bp_hold_ready%0d", c), {30'd0, req_ready}, 32'd0);
      step();
    end
    resp_ready = 2'b01;
    step();
    resp_ready = 2'b00; #1;
    chk("bp_done_valid", {30'd0, resp_valid}, 32'd0);
    chk("bp_req1_ready", {30'd0, req_ready}, 32'd2);
    step(); req_valid = 2'b00;
    step();
    chk("pass_resp_valid", {30'd0, resp_valid}, 32'd2);
    chk("pass_resp_data", resp_data, 32'hDEADBEEF);
    resp_ready = 2'b01;
    step();
    chk("pass_wrong_ready_valid", {30'd0, resp_valid}, 32'd2);
    chk("pass_wrong_ready_busy", {31'd0, busy_o}, 32'd1);
    resp_ready = 2'b10;
    step();
    chk("pass_done_busy", {31'd0, busy_o}, 32'd0);
    chk("pass_done_valid", {30'd0, resp_valid}, 32'd0);

    // Async reset while in RESP
    resp_ready = 2'b00; req0_op1 = 32'd1; req0_op2 = 32'd1; req0_ctrl = 3'd0;
    req_valid = 2'b01; #1;
    step(); req_valid = 2'b00;
    step();
    chk("mid_resp_valid", {30'd0, resp_valid}, 32'd1);
    #1 rst_n = 1'b0; #1;
    chk("arst_resp_valid", {30'd0, resp_valid}, 32'd0);
    chk("arst_busy", {31'd0, busy_o}, 32'd0);
    chk("arst_resp_data", resp_data, 32'd0);
    chk("arst_alu_op1", alu_op1_o, 32'd0);
    @(negedge clk); rst_n = 1'b1; resp_ready = 2'b11; #1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk($sformatf("post_rst_valid%0d", c), {30'd0, resp_valid}, 32'd0);
      chk($sformatf("post_rst_busy%0d", c), {31'd0, busy_o}, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single combinational ALU between two requesters, e.g. the execute stage (port 0) and a multi-cycle helper unit (port 1).
- Accepts an operation per requester over a valid/ready handshake and arbitrates round-robin.
- Drives the ALU from registered operands and captures the result in a register.
- Returns the result to the winning requester over a valid/ready response handshake.

Parameters:
DATA_WIDTH, 32, operand/result width; must match the ALU.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  2  per-requester request valid (bit i = requester i)
req_ready  output  2  per-requester accept; handshake completes on valid&ready
req0_op1, req0_op2  input  DATA_WIDTH each  requester 0 operands
req0_ctrl  input  3  requester 0 ALU function code
req1_op1, req1_op2  input  DATA_WIDTH each  requester 1 operands
req1_ctrl  input  3  requester 1 ALU function code
resp_valid  output  2  per-requester response valid
resp_ready  input  2  per-requester response accept
resp_data  output  DATA_WIDTH  registered ALU result (shared; qualified by resp_valid)
resp_zero  output  1  registered ALU zero flag
alu_op1_o, alu_op2_o  output  DATA_WIDTH each  to ALU operand inputs
alu_ctrl_o  output  3  to ALU function select
alu_out_i  input  DATA_WIDTH  from ALU result
alu_zero_i  input  1  from ALU zero flag
busy_o  output  1  high in any state other than IDLE

Behaviour:
- Function codes are passed through unchanged: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT (unsigned), 5 LSHIFT, 6 PASSOP2; code 7 behaves as ADD inside the ALU.
- FSM states: IDLE, EXEC, RESP.
- Reset (async, rst_n=0):
  - state=IDLE; priority pointer=0 (requester 0 favoured).
  - All operand, ctrl, result, zero and owner-ID registers clear to 0.
  - Outputs: req_ready=0, resp_valid=0, busy_o=0, resp_data=0, resp_zero=0, alu_*_o=0.
- IDLE:
  - req_ready is combinational.
  - If only requester i is valid, req_ready[i]=1.
  - If both are valid, the requester named by the pointer wins; only it sees ready.
  - On a handshake: latch that requester's op1/op2/ctrl and ID, then go to EXEC.
  - If nothing is valid, stay in IDLE; no request is ever accepted outside IDLE.
- EXEC (exactly 1 cycle):
  - alu_op1_o/alu_op2_o/alu_ctrl_o come from the latched registers at all times, so they are stable throughout EXEC.
  - At the end of EXEC: capture alu_out_i into resp_data and alu_zero_i into resp_zero.
  - Set the pointer to the opposite of the owner ID, then go to RESP.
- RESP:
  - resp_valid[owner]=1; the other bit is 0.
  - resp_data and resp_zero are held stable until the handshake.
  - On resp_ready[owner]: go to IDLE, and resp_valid drops the next cycle.
  - resp_ready on the non-owner bit is ignored.
- Latency: request accepted in cycle T, resp_valid high in T+2; minimum issue interval is 3 cycles.
- Requesters must hold op/ctrl stable while valid and not ready. The block needs nothing after acceptance, because the operands are latched.
- Fairness: with both requesters continuously valid, grants strictly alternate.
  - A lone requester may win back-to-back regardless of the pointer.
  - The pointer still updates after each grant.
- A deasserted req_valid in IDLE withdraws the request; the block takes no action.
- Reset mid-operation (EXEC or RESP):
  - Immediate return to IDLE and reset values; the in-flight result is discarded.
  - No resp_valid is generated after reset is released.
- resp_zero reflects the ALU flag for the final result; it is not recomputed locally.

Test Plan:
1. Reset: assert rst_n=0 in mid-RESP -> resp_valid=00, busy_o=0, resp_data=0 immediately, without waiting for a clock edge.
2. Single op: req0 ADD op1=5 op2=7, resp_ready=11 -> req_ready=01 at T; alu_*_o=5/7/0 during T+1; resp_valid=01 and resp_data=12, resp_zero=0 at T+2; IDLE at T+3.
3. Zero flag: req1 SUB op1=9 op2=9 -> resp_valid=10, resp_data=0, resp_zero=1.
4. Contention: both valid continuously, req0 OR 0xF0|0x0F, req1 LSHIFT 1<<4 -> grant order 0,1,0,1; results 0xFF then 16 alternating; one grant every 3 cycles.
5. Backpressure: req0 SLT 3<8, resp_ready=00 for 5 cycles -> resp_valid=01 and resp_data=1 held stable; req_ready=00 throughout, even with req1 valid; accepted on resp_ready[0]=1; req1 granted next in IDLE.
6. Pass-through: req1 ctrl=6 op2=0xDEADBEEF -> resp_data=0xDEADBEEF. Also drive resp_ready[0] high while req1 owns the response -> no early completion.
